// File: rtl/rtsnoc_tx_arbiter.sv
// Four-client round-robin transmit arbiter feeding a RTSNoC router local port.
// Optional lock timeout is enabled by defining RTSNOC_ARB_TIMEOUT_EN.
module rtsnoc_tx_arbiter #(
    parameter int unsigned WB_NOC_DATA_WIDTH = 32,
    parameter int unsigned SOC_SIZE_X        = 1,
    parameter int unsigned SOC_SIZE_Y        = 1,
    parameter int unsigned TIMEOUT_CYCLES    = 255,
    localparam int unsigned NOC_BUS_SIZE =
        WB_NOC_DATA_WIDTH + 2 * SOC_SIZE_X + 2 * SOC_SIZE_Y + 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [3:0]                  cli_req_i,
    input  logic [4*NOC_BUS_SIZE-1:0]   cli_din_i,
    output logic [3:0]                  cli_ack_o,
    output logic [NOC_BUS_SIZE-1:0]     noc_din_o,
    output logic                        noc_wr_o,
    input  logic                        noc_wait_i,
    output logic [1:0]                  arb_owner_o,
    output logic                        arb_busy_o,
    output logic                        arb_timeout_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StBusy = 2'd2,
        StLock = 2'd3
    } state_e;

    state_e                  r_state;
    logic [1:0]              r_last;
    logic [1:0]              r_owner;
    logic                    r_second;
    logic [NOC_BUS_SIZE-1:0] r_din;
    logic                    r_wr;
    logic [3:0]              r_ack;

    logic [NOC_BUS_SIZE-1:0] w_flit [4];
    logic [1:0]              w_win;
    logic                    w_found;
    logic                    w_is_cmd;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_flit[k] = cli_din_i[k*NOC_BUS_SIZE +: NOC_BUS_SIZE];
        end
    end

    // Search starts one past the last winner; i == 4 wraps back onto it.
    always_comb begin
        w_win   = r_last;
        w_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_found && cli_req_i[r_last + 2'(i)]) begin
                w_win   = r_last + 2'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_is_cmd = !r_second && (r_din[WB_NOC_DATA_WIDTH-1 -: 3] == 3'h0);

`ifdef RTSNOC_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_timeout;
    logic [15:0] w_cnt_inc;

    assign w_cnt_inc     = r_cnt + 16'd1;
    assign arb_timeout_o = r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign arb_timeout_o    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_last   <= 2'd3;
            r_owner  <= 2'd0;
            r_second <= 1'b0;
            r_din    <= '0;
            r_wr     <= 1'b0;
            r_ack    <= 4'b0;
`ifdef RTSNOC_ARB_TIMEOUT_EN
            r_cnt     <= 16'd0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_wr  <= 1'b0;
            r_ack <= 4'b0;
`ifdef RTSNOC_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    if (w_found && !noc_wait_i) begin
                        r_din    <= w_flit[w_win];
                        r_wr     <= 1'b1;
                        r_ack    <= 4'b0001 << w_win;
                        r_owner  <= w_win;
                        r_second <= 1'b0;
                        r_state  <= StSend;
                    end
                end
                StSend: r_state <= StBusy;
                StBusy: begin
                    if (!noc_wait_i) begin
                        if (w_is_cmd) begin
                            r_state <= StLock;
`ifdef RTSNOC_ARB_TIMEOUT_EN
                            r_cnt   <= 16'd0;
`endif
                        end else begin
                            r_state <= StIdle;
                            r_last  <= r_owner;
                        end
                    end
                end
                StLock: begin
                    // Only the owner may send its data flit; it never re-locks.
                    if (cli_req_i[r_owner] && !noc_wait_i) begin
                        r_din    <= w_flit[r_owner];
                        r_wr     <= 1'b1;
                        r_ack    <= 4'b0001 << r_owner;
                        r_second <= 1'b1;
                        r_state  <= StSend;
                    end
`ifdef RTSNOC_ARB_TIMEOUT_EN
                    else if (!cli_req_i[r_owner]) begin
                        if (w_cnt_inc == 16'(TIMEOUT_CYCLES)) begin
                            r_timeout <= 1'b1;
                            r_state   <= StIdle;
                            r_last    <= r_owner;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
`endif
                end
                default: begin
                    r_state  <= StIdle;
                    r_last   <= 2'd3;
                    r_owner  <= 2'd0;
                    r_second <= 1'b0;
                    r_din    <= '0;
`ifdef RTSNOC_ARB_TIMEOUT_EN
                    r_cnt    <= 16'd0;
`endif
                end
            endcase
        end
    end

    assign cli_ack_o   = r_ack;
    assign noc_din_o   = r_din;
    assign noc_wr_o    = r_wr;
    assign arb_owner_o = r_owner;
    assign arb_busy_o  = (r_state != StIdle);

endmodule
